// File: rtl/riscv_wb_stage_if.sv
// riscv_wb_stage_if: bundle between the memory-access stage, the load response
// path and the register-file write port of the writeback stage.
//   slave  : writeback stage side (consumes instruction + load response,
//            drives in_ready and the register-file write port)
//   master : upstream / environment side
// load_misaligned exists only when RISCV_WB_MISALIGN_CHK_EN is defined.
interface riscv_wb_stage_if #(
    parameter int unsigned WORD_LENGTH    = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
);
    localparam int unsigned OFF_W = $clog2(WORD_LENGTH / 8);

    // Upstream instruction handshake
    logic                      in_valid;
    logic                      in_ready;
    logic [1:0]                wb_sel;
    logic                      reg_we;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic [WORD_LENGTH-1:0]    alu_out;
    logic [WORD_LENGTH-1:0]    pc_plus4;
    logic [WORD_LENGTH-1:0]    csr_dout;
    logic [2:0]                load_funct3;
    logic [OFF_W-1:0]          load_addr_lo;

    // Load response
    logic                      mem_rvalid;
    logic [WORD_LENGTH-1:0]    mem_rdata;

    // Register-file write port and status pulses
    logic                      rf_we;
    logic [REG_ADDR_WIDTH-1:0] rf_waddr;
    logic [WORD_LENGTH-1:0]    rf_wdata;
    logic                      mem_timeout;
`ifdef RISCV_WB_MISALIGN_CHK_EN
    logic                      load_misaligned;
`endif

    modport slave (
        input  in_valid, wb_sel, reg_we, rd_addr, alu_out, pc_plus4, csr_dout,
               load_funct3, load_addr_lo, mem_rvalid, mem_rdata,
        output in_ready, rf_we, rf_waddr, rf_wdata, mem_timeout
`ifdef RISCV_WB_MISALIGN_CHK_EN
        , output load_misaligned
`endif
    );

    modport master (
        output in_valid, wb_sel, reg_we, rd_addr, alu_out, pc_plus4, csr_dout,
               load_funct3, load_addr_lo, mem_rvalid, mem_rdata,
        input  in_ready, rf_we, rf_waddr, rf_wdata, mem_timeout
`ifdef RISCV_WB_MISALIGN_CHK_EN
        , input load_misaligned
`endif
    );
endinterface

// File: rtl/riscv_wb_stage.sv
// riscv_wb_stage: registered, handshaked RISC-V writeback stage.
// Selects ALU / memory / PC+4 / CSR result, waits up to MEM_TIMEOUT cycles for
// load data, extracts and sign/zero-extends the loaded lane and drives a
// registered register-file write port. Stalls upstream while a load is pending.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : riscv_wb_stage_if.slave (instruction handshake, load response,
//          rf write port, mem_timeout / load_misaligned pulses)
// Optional feature: define RISCV_WB_MISALIGN_CHK_EN to suppress writes of
// misaligned loads and pulse load_misaligned instead.
module riscv_wb_stage #(
    parameter int unsigned WORD_LENGTH    = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned MEM_TIMEOUT    = 16
) (
    input logic             clk,
    input logic             rst,
    riscv_wb_stage_if.slave bus
);
    localparam int unsigned OFF_W = $clog2(WORD_LENGTH / 8);
    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC  = 2'd2;
    localparam logic [1:0] WB_CSR = 2'd3;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_WAIT_MEM = 1'b1
    } state_e;

    state_e                    state_q;
    logic [CNT_W-1:0]          cnt_q;

    // Load context captured at acceptance
    logic                      ld_we_q;
    logic [REG_ADDR_WIDTH-1:0] ld_rd_q;
    logic [2:0]                ld_f3_q;
    logic [OFF_W-1:0]          ld_off_q;

    // Registered outputs
    logic                      rf_we_q;
    logic [REG_ADDR_WIDTH-1:0] rf_waddr_q;
    logic [WORD_LENGTH-1:0]    rf_wdata_q;
    logic                      mem_timeout_q;
`ifdef RISCV_WB_MISALIGN_CHK_EN
    logic                      load_misaligned_q;
`endif

    // Non-memory result select; WB_ALU and anything unrecognised fall to alu_out
    logic [WORD_LENGTH-1:0] nm_result_c;
    always_comb begin
        nm_result_c = bus.alu_out;
        case (bus.wb_sel)
            WB_PC:   nm_result_c = bus.pc_plus4;
            WB_CSR:  nm_result_c = bus.csr_dout;
            default: nm_result_c = bus.alu_out;
        endcase
    end

    // Lane extraction: misaligned offsets round down to the lane boundary
    logic [OFF_W-1:0]       half_off_c;
    logic [OFF_W-1:0]       word_off_c;
    logic [7:0]             lane_b_c;
    logic [15:0]            lane_h_c;
    logic [31:0]            lane_w_c;
    logic [WORD_LENGTH-1:0] load_data_c;
    always_comb begin
        half_off_c  = ld_off_q & ~OFF_W'(1);
        word_off_c  = ld_off_q & ~OFF_W'(3);
        lane_b_c    = 8'(bus.mem_rdata >> {ld_off_q, 3'b000});
        lane_h_c    = 16'(bus.mem_rdata >> {half_off_c, 3'b000});
        lane_w_c    = 32'(bus.mem_rdata >> {word_off_c, 3'b000});
        load_data_c = bus.mem_rdata;
        case (ld_f3_q)
            3'b000: load_data_c = WORD_LENGTH'($signed(lane_b_c));
            3'b100: load_data_c = WORD_LENGTH'(lane_b_c);
            3'b001: load_data_c = WORD_LENGTH'($signed(lane_h_c));
            3'b101: load_data_c = WORD_LENGTH'(lane_h_c);
            // On a 32-bit datapath LW/LWU are the full word (default below)
            3'b010: if (WORD_LENGTH == 64) load_data_c = WORD_LENGTH'($signed(lane_w_c));
            3'b110: if (WORD_LENGTH == 64) load_data_c = WORD_LENGTH'(lane_w_c);
            default: load_data_c = bus.mem_rdata;
        endcase
    end

`ifdef RISCV_WB_MISALIGN_CHK_EN
    // Alignment check on the captured load type and offset
    logic misaligned_c;
    always_comb begin
        misaligned_c = 1'b0;
        case (ld_f3_q)
            3'b001, 3'b101: misaligned_c = ld_off_q[0];
            3'b010, 3'b110: misaligned_c = |ld_off_q[1:0];
            3'b011:         misaligned_c = |ld_off_q;
            default:        misaligned_c = 1'b0;
        endcase
    end
`endif

    // Writes to x0 are dropped
    logic ld_write_c;
    assign ld_write_c = ld_we_q && (ld_rd_q != '0);

    // Stage FSM, wait counter and registered write port
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            ld_we_q       <= 1'b0;
            ld_rd_q       <= '0;
            ld_f3_q       <= '0;
            ld_off_q      <= '0;
            rf_we_q       <= 1'b0;
            rf_waddr_q    <= '0;
            rf_wdata_q    <= '0;
            mem_timeout_q <= 1'b0;
`ifdef RISCV_WB_MISALIGN_CHK_EN
            load_misaligned_q <= 1'b0;
`endif
        end else begin
            rf_we_q       <= 1'b0;
            mem_timeout_q <= 1'b0;
`ifdef RISCV_WB_MISALIGN_CHK_EN
            load_misaligned_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    // in_ready is high in IDLE, so in_valid alone accepts
                    if (bus.in_valid) begin
                        if (bus.wb_sel == WB_MEM) begin
                            ld_we_q  <= bus.reg_we;
                            ld_rd_q  <= bus.rd_addr;
                            ld_f3_q  <= bus.load_funct3;
                            ld_off_q <= bus.load_addr_lo;
                            cnt_q    <= '0;
                            state_q  <= S_WAIT_MEM;
                        end else begin
                            rf_we_q    <= bus.reg_we && (bus.rd_addr != '0);
                            rf_waddr_q <= bus.rd_addr;
                            rf_wdata_q <= nm_result_c;
                        end
                    end
                end
                S_WAIT_MEM: begin
                    // Response wins over a simultaneous timeout
                    if (bus.mem_rvalid) begin
                        state_q    <= S_IDLE;
                        rf_waddr_q <= ld_rd_q;
                        rf_wdata_q <= load_data_c;
`ifdef RISCV_WB_MISALIGN_CHK_EN
                        if (misaligned_c) begin
                            load_misaligned_q <= 1'b1;
                        end else begin
                            rf_we_q <= ld_write_c;
                        end
`else
                        rf_we_q <= ld_write_c;
`endif
                    end else if (cnt_q == CNT_LAST) begin
                        mem_timeout_q <= 1'b1;
                        state_q       <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready    = (state_q == S_IDLE);
    assign bus.rf_we       = rf_we_q;
    assign bus.rf_waddr    = rf_waddr_q;
    assign bus.rf_wdata    = rf_wdata_q;
    assign bus.mem_timeout = mem_timeout_q;
`ifdef RISCV_WB_MISALIGN_CHK_EN
    assign bus.load_misaligned = load_misaligned_q;
`endif

endmodule

// File: tb/tb_riscv_wb_stage.sv
// tb_riscv_wb_stage: directed + randomized bench for riscv_wb_stage
// (32-bit datapath, MEM_TIMEOUT = 4) against a transaction-level reference.
module tb_riscv_wb_stage;
    localparam int unsigned WL = 32;
    localparam int unsigned RW = 5;
    localparam int unsigned MT = 4;

    localparam logic [1:0] SEL_ALU = 2'd0;
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_PC  = 2'd2;
    localparam logic [1:0] SEL_CSR = 2'd3;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    riscv_wb_stage_if #(.WORD_LENGTH(WL), .REG_ADDR_WIDTH(RW)) bus ();

    riscv_wb_stage #(
        .WORD_LENGTH   (WL),
        .REG_ADDR_WIDTH(RW),
        .MEM_TIMEOUT   (MT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: is a load outstanding, how many edges since acceptance
    bit         m_busy;
    int         m_age;
    logic       m_we;
    logic [4:0] m_rd;
    logic [2:0] m_f3;
    logic [1:0] m_off;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] sel, input logic [31:0] alu,
                                               input logic [31:0] pc4, input logic [31:0] csr);
        if (sel == SEL_PC)  return pc4;
        if (sel == SEL_CSR) return csr;
        return alu;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] data);
        logic [31:0] b;
        logic [31:0] h;
        int unsigned boff;
        int unsigned hoff;
        boff = 32'(off) * 8;
        hoff = (32'(off) / 2) * 16;
        b = (data >> boff) & 32'h0000_00FF;
        h = (data >> hoff) & 32'h0000_FFFF;
        case (f3)
            3'd0:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'd5:    return h;
            default: return data;
        endcase
    endfunction

`ifdef RISCV_WB_MISALIGN_CHK_EN
    function automatic bit ref_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'd1, 3'd5:       return off[0];
            3'd2, 3'd6, 3'd3: return off != 2'd0;
            default:          return 1'b0;
        endcase
    endfunction
`endif

    // Predict the outcome of the coming edge from the current inputs, then check
    task automatic step();
        bit          e_we;
        bit          e_to;
        bit          chk_data;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
`ifdef RISCV_WB_MISALIGN_CHK_EN
        bit          e_mis;
        e_mis = 1'b0;
`endif
        e_we = 1'b0; e_to = 1'b0; chk_data = 1'b0; e_addr = '0; e_data = '0;
        if (rst) begin
            m_busy   = 1'b0;
            chk_data = 1'b1;
        end else if (!m_busy) begin
            if (bus.in_valid) begin
                if (bus.wb_sel == SEL_MEM) begin
                    m_busy = 1'b1; m_age = 0;
                    m_we = bus.reg_we; m_rd = bus.rd_addr;
                    m_f3 = bus.load_funct3; m_off = bus.load_addr_lo;
                end else begin
                    e_we     = bus.reg_we && (bus.rd_addr != 5'd0);
                    e_addr   = bus.rd_addr;
                    e_data   = ref_result(bus.wb_sel, bus.alu_out, bus.pc_plus4, bus.csr_dout);
                    chk_data = e_we;
                end
            end
        end else begin
            m_age++;
            if (bus.mem_rvalid) begin
                m_busy = 1'b0;
`ifdef RISCV_WB_MISALIGN_CHK_EN
                if (ref_misaligned(m_f3, m_off)) e_mis = 1'b1;
                else
`endif
                begin
                    e_we     = m_we && (m_rd != 5'd0);
                    e_addr   = m_rd;
                    e_data   = ref_load(m_f3, m_off, bus.mem_rdata);
                    chk_data = e_we;
                end
            end else if (m_age == int'(MT)) begin
                m_busy = 1'b0;
                e_to   = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check("in_ready", 32'(bus.in_ready), 32'(!m_busy));
        check("rf_we", 32'(bus.rf_we), 32'(e_we));
        check("mem_timeout", 32'(bus.mem_timeout), 32'(e_to));
`ifdef RISCV_WB_MISALIGN_CHK_EN
        check("load_misaligned", 32'(bus.load_misaligned), 32'(e_mis));
`endif
        if (chk_data) begin
            check("rf_waddr", 32'(bus.rf_waddr), 32'(e_addr));
            check("rf_wdata", bus.rf_wdata, e_data);
        end
    endtask

    task automatic idle_in();
        bus.in_valid   = 1'b0;
        bus.mem_rvalid = 1'b0;
    endtask

    task automatic drive_nm(input logic [1:0] sel, input logic [4:0] rd, input logic [31:0] val);
        bus.in_valid = 1'b1; bus.wb_sel = sel; bus.reg_we = 1'b1; bus.rd_addr = rd;
        bus.alu_out  = $urandom; bus.pc_plus4 = $urandom; bus.csr_dout = $urandom;
        case (sel)
            SEL_PC:  bus.pc_plus4 = val;
            SEL_CSR: bus.csr_dout = val;
            default: bus.alu_out  = val;
        endcase
    endtask

    task automatic drive_ld(input logic [2:0] f3, input logic [1:0] off, input logic [4:0] rd);
        bus.in_valid = 1'b1; bus.wb_sel = SEL_MEM; bus.reg_we = 1'b1; bus.rd_addr = rd;
        bus.load_funct3 = f3; bus.load_addr_lo = off;
    endtask

    initial begin
        n_vec = 0; n_err = 0; m_busy = 1'b0; m_age = 0;
        m_we = 1'b0; m_rd = '0; m_f3 = '0; m_off = '0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.wb_sel = SEL_ALU; bus.reg_we = 1'b0; bus.rd_addr = '0;
        bus.alu_out = '0; bus.pc_plus4 = '0; bus.csr_dout = '0;
        bus.load_funct3 = '0; bus.load_addr_lo = '0;
        bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;

        // Reset state
        step(); step();
        rst = 1'b0;
        step();

        // ALU, PC, CSR back to back
        drive_nm(SEL_ALU, 5'd5, 32'h0000_0011); step();
        drive_nm(SEL_PC,  5'd6, 32'h0000_0104); step();
        drive_nm(SEL_CSR, 5'd7, 32'h0000_ABCD); step();
        idle_in(); step();

        // LB / LBU, addr_lo = 3, response 3 cycles after acceptance
        for (int k = 0; k < 2; k++) begin
            drive_ld((k == 0) ? 3'b000 : 3'b100, 2'd3, 5'd8); step();
            idle_in(); step(); step();
            bus.mem_rdata = 32'h80FF_0000; bus.mem_rvalid = 1'b1; step();
            idle_in(); step();
        end

        // LH to x0: response consumed, no write
        drive_ld(3'b001, 2'd0, 5'd0); step();
        idle_in(); step();
        bus.mem_rdata = 32'h1234_8765; bus.mem_rvalid = 1'b1; step();
        idle_in(); step();

        // Timeout with no response
        drive_ld(3'b010, 2'd0, 5'd10); step();
        idle_in(); step(); step(); step(); step();
        step();

        // Response on the timeout cycle wins
        drive_ld(3'b010, 2'd0, 5'd10); step();
        idle_in(); step(); step(); step();
        bus.mem_rdata = 32'hCAFE_F00D; bus.mem_rvalid = 1'b1; step();
        idle_in(); step();

        // Reset while waiting, then a stray response in IDLE
        drive_ld(3'b010, 2'd0, 5'd11); step();
        idle_in(); step();
        rst = 1'b1; bus.mem_rdata = 32'h5555_AAAA; bus.mem_rvalid = 1'b1; step();
        rst = 1'b0; step();
        idle_in(); step();

        // LW with addr_lo = 2
        drive_ld(3'b010, 2'd2, 5'd9); step();
        idle_in();
        bus.mem_rdata = 32'hDEAD_BEEF; bus.mem_rvalid = 1'b1; step();
        idle_in(); step();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst              = ($urandom_range(0, 59) == 0);
            bus.in_valid     = ($urandom_range(0, 9) < 6);
            bus.wb_sel       = 2'($urandom);
            bus.reg_we       = 1'($urandom);
            bus.rd_addr      = 5'($urandom);
            bus.alu_out      = $urandom;
            bus.pc_plus4     = $urandom;
            bus.csr_dout     = $urandom;
            bus.load_funct3  = 3'($urandom);
            bus.load_addr_lo = 2'($urandom);
            bus.mem_rdata    = $urandom;
            bus.mem_rvalid   = ($urandom_range(0, 9) < 3);
            step();
        end
        rst = 1'b0;
        idle_in(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/riscv_wb_stage.md
# riscv_wb_stage

Registered, handshaked writeback stage for the RISC-V core. It is the parametrised successor to the combinational writeback select. It selects among ALU, memory, PC+4 and CSR results. It waits a bounded number of cycles for load data and extracts and sign-extends the loaded byte, half or word. It drives a registered register-file write port. It sits between the memory-access stage and the register file, and stalls upstream while a load is outstanding.

## Interface
Parameters:
- `WORD_LENGTH`, 32, datapath width; must be 32 or 64.
- `REG_ADDR_WIDTH`, 5, register index width.
- `MEM_TIMEOUT`, 16, maximum cycles to wait for `mem_rvalid` (≥2).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  upstream has an instruction for writeback.
- `in_ready`  out  1  stage can accept; equals (state == IDLE).
- `wb_sel`  in  WB_SEL  source select (WB_ALU / WB_MEM / WB_PC / WB_CSR).
- `reg_we`  in  1  instruction writes rd.
- `rd_addr`  in  REG_ADDR_WIDTH  destination register.
- `alu_out`, `pc_plus4`, `csr_dout`  in  WORD_LENGTH  non-memory sources.
- `load_funct3`  in  3  load type: 000 LB, 001 LH, 010 LW, 011 LD (64 only), 100 LBU, 101 LHU, 110 LWU (64 only).
- `load_addr_lo`  in  $clog2(WORD_LENGTH/8)  byte offset of the load within the word.
- `mem_rvalid`  in  1  load data valid.
- `mem_rdata`  in  WORD_LENGTH  load data; little-endian lanes.
- `rf_we`  out  1  register-file write enable (1-cycle pulse).
- `rf_waddr`  out  REG_ADDR_WIDTH  write index.
- `rf_wdata`  out  WORD_LENGTH  write data.
- `mem_timeout`  out  1  1-cycle pulse: load abandoned.
- `load_misaligned`  out  1  1-cycle pulse; present only with `RISCV_WB_MISALIGN_CHK_EN`.

## Operation
- States: IDLE, WAIT_MEM.
- An instruction is accepted when `in_valid && in_ready`.
- **IDLE, non-memory acceptance** (`wb_sel` ≠ WB_MEM):
  - Result is `pc_plus4` for WB_PC, `csr_dout` for WB_CSR, else `alu_out` (any unknown encoding uses `alu_out`).
  - Next cycle: `rf_we = reg_we && rd_addr != 0`, `rf_waddr = rd_addr`, `rf_wdata = result`.
  - State stays IDLE; throughput is 1 instruction per cycle.
- **IDLE, WB_MEM acceptance:**
  - Capture `reg_we`, `rd_addr`, `load_funct3` and `load_addr_lo`.
  - Clear the wait counter and go to WAIT_MEM.
- **WAIT_MEM:**
  - `in_ready = 0`; the counter increments each cycle.
  - On `mem_rvalid`: extract the lane, register the write next cycle (same rd/x0 rule), go to IDLE.
  - If the counter reaches `MEM_TIMEOUT-1` without `mem_rvalid`: pulse `mem_timeout` next cycle, no write, go to IDLE.
  - `mem_rvalid` and timeout in the same cycle: `mem_rvalid` wins.
- `mem_rvalid` in IDLE is ignored.
- **Extraction:**
  - Byte lane = `load_addr_lo`; half lane = `load_addr_lo` with bit 0 cleared; word lane (64-bit) = bit 2 only.
  - LB/LH/LW sign-extend to WORD_LENGTH; LBU/LHU/LWU zero-extend.
  - LD returns the full word. LW on 32-bit returns the full word.
  - Encodings 111, and LD/LWU on 32-bit, are treated as a full-word load.
- **Reset** (any state, including mid-WAIT_MEM):
  - State goes to IDLE and the counter clears.
  - A pending load is dropped with no write.
  - `rf_we`, `rf_waddr`, `rf_wdata`, `mem_timeout`, `load_misaligned` all reset to 0; `in_ready` = 1 after reset.

## Timing
- Non-memory result: `rf_we` asserts the cycle after acceptance.
- Load: `rf_we` asserts the cycle after `mem_rvalid`; minimum load latency is 2 cycles from acceptance (`mem_rvalid` is never sampled in the acceptance cycle).
- `mem_timeout` asserts `MEM_TIMEOUT` cycles after acceptance.
- A new instruction may be accepted in the same cycle that `rf_we` for the previous one is high.
- All outputs except `in_ready` are registered.

## Configuration
- `RISCV_WB_MISALIGN_CHK_EN` defined:
  - LH/LHU with `load_addr_lo[0]`=1, LW/LWU with any of the low 2 bits set, or LD with any of the low 3 bits set, counts as misaligned.
  - The response is still consumed. `rf_we` stays 0, and `load_misaligned` pulses in the cycle the write would have occurred.
- Not defined:
  - No `load_misaligned` port.
  - Misaligned offsets are rounded down to the lane boundary per the extraction rules, and the write proceeds.

## Test plan
- ALU, then PC, then CSR back-to-back, rd=5/6/7 (values 0x11, 0x104, 0xABCD) -> `rf_we` high 3 consecutive cycles with matching addr/data; `in_ready` stays 1.
- LB, addr_lo=3, `mem_rdata`=0x80FF_0000, `mem_rvalid` 3 cycles after acceptance -> `in_ready` low for 3 cycles, then `rf_wdata`=0xFFFF_FF80; same with LBU -> 0x0000_0080.
- LH to rd=0 with valid data -> `rf_we` stays 0, state returns to IDLE.
- `MEM_TIMEOUT`=4, no `mem_rvalid` -> `mem_timeout` pulses 4 cycles after acceptance, no write; `mem_rvalid` on the timeout cycle instead -> write occurs, no `mem_timeout`.
- `rst` asserted during WAIT_MEM, then `mem_rvalid` -> no write, all outputs 0, `in_ready`=1.
- With macro: LW, addr_lo=2 -> `load_misaligned` pulse, `rf_we`=0. Without macro -> `rf_wdata` = full word.
